wide_inv: RTL and testbench
===========================

WIDE_INV -- requirements
Module: wide_inv

Interface
REQ-001 Parameter WIDTH, default 32: data path width in bits; SHALL support any value 1..64.
REQ-002 Parameter LATENCY, default 1: number of register stages from d_in to d_out; SHALL support 1..4.
REQ-003 Port clock, input, 1: single clock; all state SHALL update on its rising edge only.
REQ-004 Port rst, input, 1: reset, asynchronous assertion, active-low (0 = reset).
REQ-005 Port d_in, input, WIDTH: data word to be inverted; sampled every rising clock edge, no valid qualifier.
REQ-006 Port d_out, output, WIDTH: registered bitwise complement of d_in.
REQ-007 The block SHALL have exactly these four ports and no other clock or reset.

Function
REQ-008 Each cycle, stage 1 SHALL capture ~d_in (bitwise NOT, all WIDTH bits, no sign or arithmetic interpretation).
REQ-009 Stage k (2..LATENCY) SHALL capture stage k-1 unchanged; d_out SHALL be driven directly from the last stage register, with no combinational path from d_in to d_out.
REQ-010 d_out at edge N+LATENCY SHALL equal ~(d_in sampled at edge N), bit for bit.
REQ-011 Throughput: one new word accepted every cycle; no stalls, no back-pressure, no handshake.
REQ-012 Every bit position SHALL be independent: d_out[i] depends only on d_in[i] for all i.
REQ-013 X/Z on a d_in bit SHALL affect only the corresponding d_out bit; other bits SHALL be unaffected.
REQ-014 LATENCY outside 1..4 or WIDTH outside 1..64 SHALL be rejected at elaboration with an error.

Reset
REQ-015 While rst=0, all stage registers and d_out SHALL be all-zeros, immediately and without waiting for a clock edge.
REQ-016 Reset deassertion (rst 0->1) SHALL be treated synchronously: the first capture occurs on the first rising edge at which rst=1.
REQ-017 After deassertion, d_out SHALL remain all-zeros until LATENCY capture edges have elapsed, then follow REQ-010.
REQ-018 Reset asserted mid-stream SHALL discard all in-flight words; none SHALL appear on d_out after reset is released.

Verification
REQ-019 Reset: rst=0 for 2 cycles with d_in=32'hFFFFFFFF -> d_out=32'h00000000 throughout, including before the first clock edge.
REQ-020 Directed sequence, default parameters, one word per cycle: d_in = 00000000, FFFFFFFF, FFFF0000, 0000FFFF, 55555555, AAAAAAAA, 11111111, 22222222, 44444444, 88888888 -> d_out one cycle later = FFFFFFFF, 00000000, 0000FFFF, FFFF0000, AAAAAAAA, 55555555, EEEEEEEE, DDDDDDDD, BBBBBBBB, 77777777.
REQ-021 Walking-one: d_in = 1<<i for i=0..31 -> d_out = ~(1<<i) one cycle later; confirms bit independence and no bit swaps.
REQ-022 LATENCY=3: d_in=12345678 for one cycle, then 0 -> d_out=EDCBA987 exactly 3 edges later for exactly one cycle, then FFFFFFFF.
REQ-023 Mid-stream reset: stream random words, assert rst=0 asynchronously between edges -> d_out=0 immediately; after release, no pre-reset word ever appears on d_out.
REQ-024 Random: 10,000 random d_in words with random WIDTH in {1,8,32,64} -> every d_out equals the bitwise complement of the d_in sampled LATENCY edges earlier.

Source files
------------

// File: rtl/wide_inv.sv
// wide_inv: bitwise inverter behind LATENCY register stages. The first stage
// captures ~d_in and the later stages only delay it, so d_out is always a flop output.
module wide_inv #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 1
) (
  input  logic             clock,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] d_out
);

  if (WIDTH < 1 || WIDTH > 64) begin : g_badWidth
    $error("wide_inv: WIDTH=%0d is outside the supported range 1..64", WIDTH);
  end

  if (LATENCY < 1 || LATENCY > 4) begin : g_badLatency
    $error("wide_inv: LATENCY=%0d is outside the supported range 1..4", LATENCY);
  end

  logic [WIDTH-1:0] r_stage [LATENCY];

  // Reset clears every stage at once, so in-flight words are dropped, not delayed.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < LATENCY; k++) begin
        r_stage[k] <= '0;
      end
    end else begin
      r_stage[0] <= ~d_in;
      for (int k = 1; k < LATENCY; k++) begin
        r_stage[k] <= r_stage[k-1];
      end
    end
  end

  assign d_out = r_stage[LATENCY-1];

endmodule

// File: tb/tb_wide_inv.sv
// tb_wide_inv: drives five wide_inv instances of different WIDTH/LATENCY with one
// shared clock and reset, and checks each of them against a log of captured words.
module tb_wide_inv;

  localparam int NUM = 5;
  localparam int LAT [NUM] = '{1, 3, 1, 2, 4};
  localparam int WID [NUM] = '{32, 32, 1, 8, 64};

  logic        clock;
  logic        rst;
  logic [31:0] din0, dout0;
  logic [31:0] din1, dout1;
  logic [0:0]  din2, dout2;
  logic [7:0]  din3, dout3;
  logic [63:0] din4, dout4;

  int errors = 0;
  int checks = 0;

  // Every word accepted since the last reset, one entry per capture edge.
  logic [NUM-1:0][63:0] capLog[$];
  int sinceReset = 0;

  wide_inv #(.WIDTH(32), .LATENCY(1)) u_w32l1 (.clock(clock), .rst(rst), .d_in(din0), .d_out(dout0));
  wide_inv #(.WIDTH(32), .LATENCY(3)) u_w32l3 (.clock(clock), .rst(rst), .d_in(din1), .d_out(dout1));
  wide_inv #(.WIDTH(1),  .LATENCY(1)) u_w1l1  (.clock(clock), .rst(rst), .d_in(din2), .d_out(dout2));
  wide_inv #(.WIDTH(8),  .LATENCY(2)) u_w8l2  (.clock(clock), .rst(rst), .d_in(din3), .d_out(dout3));
  wide_inv #(.WIDTH(64), .LATENCY(4)) u_w64l4 (.clock(clock), .rst(rst), .d_in(din4), .d_out(dout4));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [63:0] maskOf(input int i);
    if (WID[i] >= 64) return '1;
    return (64'd1 << WID[i]) - 64'd1;
  endfunction

  function automatic logic [63:0] observed(input int i);
    case (i)
      0:       return {32'd0, dout0};
      1:       return {32'd0, dout1};
      2:       return {63'd0, dout2};
      3:       return {56'd0, dout3};
      default: return dout4;
    endcase
  endfunction

  // Expected output: zero until LATENCY words have been accepted, then the
  // complement of the word accepted LATENCY captures ago.
  function automatic logic [63:0] expectedOut(input int i);
    if (sinceReset < LAT[i]) return 64'd0;
    return ~capLog[capLog.size() - LAT[i]][i] & maskOf(i);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    for (int i = 0; i < NUM; i++) begin
      checkOutput($sformatf("%s_u%0d", tag, i), observed(i), expectedOut(i));
    end
  endtask

  // Drives one word per instance, lets one rising edge pass, then checks at the falling edge.
  task automatic applyStimulus(input logic [NUM-1:0][63:0] vin, input string tag);
    logic [NUM-1:0][63:0] v;
    for (int i = 0; i < NUM; i++) v[i] = vin[i] & maskOf(i);
    din0 = v[0][31:0];
    din1 = v[1][31:0];
    din2 = v[2][0:0];
    din3 = v[3][7:0];
    din4 = v[4];
    @(posedge clock);
    if (rst) begin
      capLog.push_back(v);
      sinceReset++;
      if (capLog.size() > 8) void'(capLog.pop_front());
    end
    @(negedge clock);
    checkAll(tag);
  endtask

  function automatic logic [NUM-1:0][63:0] sameWord(input logic [31:0] w);
    logic [NUM-1:0][63:0] v;
    for (int i = 0; i < NUM; i++) v[i] = {w, w};
    return v;
  endfunction

  function automatic logic [NUM-1:0][63:0] randomWords();
    logic [NUM-1:0][63:0] v;
    for (int i = 0; i < NUM; i++) v[i] = {$urandom(), $urandom()};
    return v;
  endfunction

  logic [31:0] dirIn  [10] = '{32'h00000000, 32'hFFFFFFFF, 32'hFFFF0000, 32'h0000FFFF, 32'h55555555,
                               32'hAAAAAAAA, 32'h11111111, 32'h22222222, 32'h44444444, 32'h88888888};
  logic [31:0] dirOut [10] = '{32'hFFFFFFFF, 32'h00000000, 32'h0000FFFF, 32'hFFFF0000, 32'hAAAAAAAA,
                               32'h55555555, 32'hEEEEEEEE, 32'hDDDDDDDD, 32'hBBBBBBBB, 32'h77777777};
  logic [31:0] lat3Out [6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hEDCBA987,
                               32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};

  initial begin
    logic [31:0] one;
    one  = 32'h1;
    rst  = 1'b1;
    din0 = '1;
    din1 = '1;
    din2 = '1;
    din3 = '1;
    din4 = '1;

    // Reset with all-ones inputs: outputs must clear before any clock edge.
    #1 rst = 1'b0;
    #1 checkAll("rst_preclk");
    @(negedge clock);
    checkAll("rst_c1");
    @(negedge clock);
    checkAll("rst_c2");
    rst = 1'b1;

    for (int k = 0; k < 10; k++) begin
      applyStimulus(sameWord(dirIn[k]), "dir");
      checkOutput($sformatf("dir_const%0d", k), {32'd0, dout0}, {32'd0, dirOut[k]});
    end

    for (int i = 0; i < 32; i++) begin
      applyStimulus(sameWord(one << i), "walk");
      checkOutput($sformatf("walk_const%0d", i), {32'd0, dout0}, {32'd0, ~(one << i)});
    end

    // Fill the three-stage pipe with zeros, then send a single marker word.
    for (int k = 0; k < 4; k++) applyStimulus(sameWord(32'h0), "lat3_fill");
    for (int k = 0; k < 6; k++) begin
      applyStimulus(sameWord(k == 0 ? 32'h12345678 : 32'h0), "lat3");
      checkOutput($sformatf("lat3_const%0d", k), {32'd0, dout1}, {32'd0, lat3Out[k]});
    end

    for (int k = 0; k < 20; k++) applyStimulus(randomWords(), "pre_rst");
    #2 rst = 1'b0;
    #1;
    capLog.delete();
    sinceReset = 0;
    for (int i = 0; i < NUM; i++) checkOutput($sformatf("midrst_async_u%0d", i), observed(i), 64'd0);
    applyStimulus(randomWords(), "midrst_hold");
    rst = 1'b1;
    for (int k = 0; k < 10; k++) applyStimulus(randomWords(), "post_rst");

    for (int k = 0; k < 10000; k++) applyStimulus(randomWords(), "rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
